// File: rtl/alu_pipe_if.sv
// Operand/opcode request and result response bundle for alu_pipe.
// master = environment (source + consumer), slave = the ALU block.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, flags, err
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, flags, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with carry-chained ADC/SBB, {V,C,N,Z} flags and valid/ready on both sides.
// Optional: define ALU_SATURATE_EN to clamp signed-overflowing arithmetic instead of wrapping.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_CLR  = 4'b0001,
        OP_ADD  = 4'b0100,
        OP_SUB  = 4'b0101,
        OP_ADC  = 4'b0110,
        OP_SBB  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_NAND = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_NOT  = 4'b1101
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
        logic             err;
    } rsp_t;

    logic             cy_q;
    logic             vld_q;
    rsp_t             rsp_q;

    logic             accept;
    logic             produce;
    logic             is_arith;
    logic             is_sub;
    logic             illegal;
    logic             cin;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             c_n;
    logic             v_n;
    rsp_t             rsp_n;

    assign bus.in_ready  = !vld_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = vld_q;
    assign bus.result    = rsp_q.result;
    assign bus.flags     = rsp_q.flags;
    assign bus.err       = rsp_q.err;

    always_comb begin
        is_arith = 1'b0;
        is_sub   = 1'b0;
        illegal  = 1'b0;
        produce  = 1'b1;
        cin      = 1'b0;
        ext      = '0;
        res      = '0;
        unique case (bus.opcode)
            OP_NOP, OP_CLR: produce = 1'b0;
            OP_ADD:  is_arith = 1'b1;
            OP_ADC: begin is_arith = 1'b1; cin = cy_q; end
            OP_SUB: begin is_arith = 1'b1; is_sub = 1'b1; end
            OP_SBB: begin is_arith = 1'b1; is_sub = 1'b1; cin = cy_q; end
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NAND: res = ~(bus.a & bus.b);
            OP_NOR:  res = ~(bus.a | bus.b);
            OP_NOT:  res = ~bus.a;
            default: illegal = 1'b1;
        endcase

        // One extra bit: carry-out for add, borrow (sign of a-b-cy) for subtract.
        if (is_sub)
            ext = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH+1)'(cin);
        else
            ext = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(cin);

        c_n = is_arith && ext[WIDTH];
        v_n = 1'b0;
        if (is_arith) begin
            res = ext[MSB:0];
            if (is_sub)
                v_n = (bus.a[MSB] != bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
            else
                v_n = (bus.a[MSB] == bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
`ifdef ALU_SATURATE_EN
            if (v_n)
                res = bus.a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`else
`endif
        end

        rsp_n.result = res;
        rsp_n.flags  = {v_n, c_n, res[MSB], (res == '0)};
        rsp_n.err    = illegal;
        if (illegal) rsp_n = '{result: '0, flags: 4'b0000, err: 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
            cy_q  <= 1'b0;
        end else begin
            if (accept && produce) begin
                vld_q <= 1'b1;
                rsp_q <= rsp_n;
            end else if (bus.out_ready) begin
                vld_q <= 1'b0;
            end

            if (accept && is_arith)
                cy_q <= c_n;
            else if (accept && bus.opcode == OP_CLR)
                cy_q <= 1'b0;
        end
    end
endmodule
